// File: rtl/mult_div.sv
// ============================================================================
// mult_div -- multi-cycle multiply/divide unit with the HI/LO register pair.
//
// Executes MULT, MULTU, DIV, DIVU (multi-cycle, busy asserted) and MTHI/MTLO
// (single-cycle, busy stays low). Operands are latched when a multiply/divide
// is accepted. The result is computed from the latched operands and written
// into HI/LO on the edge that ends the busy window.
//
// Parameters
//   MULT_CYCLES : busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES  : busy cycles for DIV/DIVU   (>= 1)
//
// Ports
//   clk   in   1  rising-edge clock
//   reset in   1  asynchronous, active-high; clears all state
//   start in   1  E-stage instruction is MULT/MULTU/DIV/DIVU (qualified by op)
//   op    in   3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, else no-op
//   we    in   1  E-stage instruction is MTHI/MTLO (qualified by op)
//   A     in  32  rs operand
//   B     in  32  rt operand
//   busy  out  1  operation in progress (registered)
//   HI    out 32  HI register
//   LO    out 32  LO register
// ============================================================================
module mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        we,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [1:0]       op_reg;      // only ops 0..3 are ever latched
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    // Decoded view of the latched op: bit 1 selects divide, bit 0 unsigned.
    logic is_div;
    logic is_signed;

    assign is_div    = op_reg[1];
    assign is_signed = ~op_reg[0];

    // ------------------------------------------------------------------------
    // Multiplier: one 33x33 signed multiply covers both MULT and MULTU.
    // The extra top bit is the sign extension for MULT and zero for MULTU,
    // so the low 64 bits of the product are the correct result in both cases.
    // ------------------------------------------------------------------------
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] mul_full;
    logic [63:0]        mul_res;
    logic               unused_mul_top;

    assign mul_a          = {is_signed & a_reg[31], a_reg};
    assign mul_b          = {is_signed & b_reg[31], b_reg};
    assign mul_full       = mul_a * mul_b;
    assign mul_res        = mul_full[63:0];
    assign unused_mul_top = ^mul_full[65:64];

    // ------------------------------------------------------------------------
    // Divider: unsigned restoring array on operand magnitudes, signs fixed up
    // afterwards. Quotient is negative when the operand signs differ; the
    // remainder follows the dividend's sign. The 0x80000000 / -1 case falls
    // out naturally: magnitude quotient 0x80000000, signs equal, remainder 0.
    // ------------------------------------------------------------------------
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo_res;
    logic [31:0] rem_res;
    logic [31:0] rem_chain [0:32];

    assign dvd_neg = is_signed & a_reg[31];
    assign dvs_neg = is_signed & b_reg[31];
    assign dvd_mag = dvd_neg ? (~a_reg + 32'd1) : a_reg;
    assign dvs_mag = dvs_neg ? (~b_reg + 32'd1) : b_reg;

    assign rem_chain[0] = '0;

    // Stage gi resolves quotient bit 31-gi: shift in the next dividend bit,
    // try subtracting the divisor, keep the difference if it did not borrow.
    for (genvar gi = 0; gi < 32; gi++) begin : g_div_stage
        logic [32:0] shifted;
        logic [33:0] trial;
        logic        unused_trial_bit;

        assign shifted             = {rem_chain[gi], dvd_mag[31-gi]};
        assign trial               = {1'b0, shifted} - {2'b00, dvs_mag};
        assign quo_mag[31-gi]      = ~trial[33];
        // A non-borrowing difference is below the divisor, so bit 32 is zero.
        assign rem_chain[gi+1]     = trial[33] ? shifted[31:0] : trial[31:0];
        assign unused_trial_bit    = trial[32];
    end

    assign rem_mag = rem_chain[32];
    assign quo_res = (dvd_neg ^ dvs_neg) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_res = dvd_neg ? (~rem_mag + 32'd1) : rem_mag;

    // ------------------------------------------------------------------------
    // Result selection for the terminal edge. A zero divisor suppresses the
    // write so HI/LO keep their previous contents.
    // ------------------------------------------------------------------------
    logic        res_wr;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        res_wr = 1'b1;
        res_hi = mul_res[63:32];
        res_lo = mul_res[31:0];
        if (is_div) begin
            res_hi = rem_res;
            res_lo = quo_res;
            if (b_reg == 32'd0) begin
                res_wr = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control and register update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // start takes priority over we even when its op is
                        // not a multiply/divide; such a start is a no-op.
                        if (!op[2]) begin
                            op_reg    <= op[1:0];
                            a_reg     <= A;
                            b_reg     <= B;
                            count_reg <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state_reg <= ST_RUN;
                        end
                    end else if (we) begin
                        if (op == OP_MTHI) begin
                            hi_reg <= A;
                        end else if (op == OP_MTLO) begin
                            lo_reg <= A;
                        end
                    end
                end

                ST_RUN: begin
                    // Counter was loaded with N at acceptance; reaching 1
                    // here means this is the N-th edge since then.
                    if (count_reg == CNT_W'(1)) begin
                        if (res_wr) begin
                            hi_reg <= res_hi;
                            lo_reg <= res_lo;
                        end
                        count_reg <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mult_div.sv
// ============================================================================
// tb_mult_div -- self-checking bench for mult_div.
//
// A behavioural model tracks HI, LO and the cycle at which the pending
// operation completes, computing results with plain integer arithmetic.
// A compare process checks busy/HI/LO against the model on every falling
// edge. Directed transactions pin the model with literal expectations, then
// a randomized phase drives start/we/op/operands and occasional resets.
// ============================================================================
module tb_mult_div;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        we    = 1'b0;
    logic [2:0]  op    = 3'd7;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;

    mult_div #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .we   (we),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------------
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, output bit wr,
                                   output logic [31:0] hi, output logic [31:0] lo);
        int              sa;
        int              sb;
        longint          p;
        longint unsigned pu;
        sa = a;
        sb = b;
        wr = 1'b1;
        hi = '0;
        lo = '0;
        case (o)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                {hi, lo} = p;
            end
            3'd1: begin
                pu = 64'(a) * 64'(b);
                {hi, lo} = pu;
            end
            3'd2: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: pending op completes at a known cycle number
    // ------------------------------------------------------------------------
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    bit          m_pend = 1'b0;
    longint      m_cyc  = 0;
    longint      m_done = 0;
    bit          m_rwr  = 1'b0;
    logic [31:0] m_rhi  = '0;
    logic [31:0] m_rlo  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = 1'b0;
        end else begin
            m_cyc++;
            if (m_pend) begin
                if (m_cyc == m_done) begin
                    if (m_rwr) begin
                        m_hi = m_rhi;
                        m_lo = m_rlo;
                    end
                    m_pend = 1'b0;
                end
            end else if (start) begin
                if (op <= 3'd3) begin
                    m_pend = 1'b1;
                    m_done = m_cyc + ((op < 3'd2) ? MULT_N : DIV_N);
                    ref_op(op, A, B, m_rwr, m_rhi, m_rlo);
                end
            end else if (we) begin
                if (op == 3'd4) m_hi = A;
                else if (op == 3'd5) m_lo = A;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_pend));
        chk("HI",   64'(HI),   64'(m_hi));
        chk("LO",   64'(LO),   64'(m_lo));
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    // Wait (bounded) for busy to drop; returns busy length relative to k_cyc.
    task automatic wait_idle(input int k_cyc, output int len);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        len = tb_cyc - k_cyc;
    endtask

    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b, output int len);
        int k;
        @(posedge clk); #2;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #2;
        k = tb_cyc;
        start = 1'b0; op = 3'd7; A = $urandom; B = $urandom;
        wait_idle(k, len);
        $display("txn %s A=%h B=%h busy_cycles=%0d HI=%h LO=%h", name, a, b, len, HI, LO);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        @(posedge clk); #2;
        we = 1'b1; op = o; A = a;
        @(posedge clk); #2;
        we = 1'b0; op = 3'd7; A = $urandom;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'(-$urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int len;
        int k;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_HI",   64'(HI),   64'd0);
        chk("reset_LO",   64'(LO),   64'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // MULT -3 * 5
        run_op("MULT", 3'd0, 32'hFFFF_FFFD, 32'd5, len);
        chk("mult_len", 64'(len), 64'd5);
        chk("mult_HI",  64'(HI),  64'hFFFF_FFFF);
        chk("mult_LO",  64'(LO),  64'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF * 2
        run_op("MULTU", 3'd1, 32'hFFFF_FFFF, 32'd2, len);
        chk("multu_len", 64'(len), 64'd5);
        chk("multu_HI",  64'(HI),  64'h0000_0001);
        chk("multu_LO",  64'(LO),  64'hFFFF_FFFE);

        // DIV -7 / 2, then DIVU 7 / 2
        run_op("DIV", 3'd2, 32'hFFFF_FFF9, 32'd2, len);
        chk("div_len", 64'(len), 64'd10);
        chk("div_HI",  64'(HI),  64'hFFFF_FFFF);
        chk("div_LO",  64'(LO),  64'hFFFF_FFFD);
        run_op("DIVU", 3'd3, 32'd7, 32'd2, len);
        chk("divu_HI", 64'(HI), 64'd1);
        chk("divu_LO", 64'(LO), 64'd3);

        // Signed overflow case
        run_op("DIV_OVF", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, len);
        chk("ovf_HI", 64'(HI), 64'd0);
        chk("ovf_LO", 64'(LO), 64'h8000_0000);

        // Divide by zero keeps HI/LO
        mt(3'd4, 32'h11);
        mt(3'd5, 32'h22);
        run_op("DIVU_Z", 3'd3, 32'd9, 32'd0, len);
        chk("dz_len", 64'(len), 64'd10);
        chk("dz_HI",  64'(HI),  64'h11);
        chk("dz_LO",  64'(LO),  64'h22);

        // MTHI one edge later, busy stays low
        mt(3'd4, 32'hABCD);
        @(negedge clk);
        chk("mthi_HI",   64'(HI),   64'hABCD);
        chk("mthi_busy", 64'(busy), 64'd0);
        $display("txn MTHI A=0000abcd HI=%h LO=%h", HI, LO);

        // Requests during busy are ignored
        @(posedge clk); #2;
        start = 1'b1; op = 3'd0; A = 32'd6; B = 32'd7;
        @(posedge clk); #2;
        k = tb_cyc;
        start = 1'b0; op = 3'd7;
        @(posedge clk); #2;
        start = 1'b1; we = 1'b1; op = 3'd2; A = 32'd100; B = 32'd3;
        @(posedge clk); #2;
        start = 1'b0; we = 1'b1; op = 3'd5; A = 32'h5555;
        @(posedge clk); #2;
        we = 1'b0; op = 3'd7;
        wait_idle(k, len);
        chk("ign_len", 64'(len), 64'd5);
        chk("ign_HI",  64'(HI),  64'd0);
        chk("ign_LO",  64'(LO),  64'd42);
        $display("txn MULT_IGN A=00000006 B=00000007 busy_cycles=%0d HI=%h LO=%h", len, HI, LO);

        // Reset mid-operation
        @(posedge clk); #2;
        start = 1'b1; op = 3'd0; A = 32'd1000; B = 32'd1000;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd7;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_HI",   64'(HI),   64'd0);
        chk("rst_LO",   64'(LO),   64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rst_after_HI",   64'(HI),   64'd0);
        chk("rst_after_LO",   64'(LO),   64'd0);
        chk("rst_after_busy", 64'(busy), 64'd0);
        $display("txn RESET_MID HI=%h LO=%h", HI, LO);
        run_op("MULTU", 3'd1, 32'd3, 32'd4, len);
        chk("post_len", 64'(len), 64'd5);
        chk("post_HI",  64'(HI),  64'd0);
        chk("post_LO",  64'(LO),  64'd12);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) reset = 1'b1;
            start = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
        end
        @(posedge clk); #2;
        reset = 1'b0; start = 1'b0; we = 1'b0; op = 3'd7;
        wait_idle(tb_cyc, len);
        chk("final_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
